// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 16-bit unsigned multiply/divide side unit.
// Shift-add multiplier and restoring divider share a single FSM and counter.
// The result is written back through the register file write port with a one-cycle wb_en pulse.
// CALC first spends one cycle loading the datapath from the latched operands.
// It then runs WIDTH iterations, so done rises WIDTH+1 edges after the accept edge.
module mul_div_unit #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      src_a,
    input  logic [WIDTH-1:0]      src_b,
    input  logic [REG_ADDR_W-1:0] dest,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [WIDTH-1:0]      wb_data
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_t;

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);

    state_t                  state;
    op_t                     op_r;
    logic [WIDTH-1:0]        a_r;       // multiplicand / dividend
    logic [WIDTH-1:0]        b_r;       // multiplier / divisor
    logic [REG_ADDR_W-1:0]   dest_r;
    logic [CNT_W-1:0]        cnt;       // 0 = load cycle, 1..WIDTH = iterations
    logic [2*WIDTH-1:0]      prod;      // {partial high half, remaining multiplier bits}
    logic [WIDTH:0]          rem;       // partial remainder, one guard bit
    logic [WIDTH-1:0]        quot;      // dividend bits shift out, quotient bits shift in

    logic [WIDTH:0]          mul_sum;
    logic [2*WIDTH-1:0]      prod_next;
    logic [WIDTH:0]          div_shift;
    logic [WIDTH:0]          div_diff;
    logic                    div_fits;
    logic [WIDTH:0]          rem_next;
    logic [WIDTH-1:0]        quot_next;
    logic [WIDTH-1:0]        result_next;

    // One shift-add multiply step: add the multiplicand if the LSB is set, then shift right.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
    assign prod_next = {mul_sum, prod[WIDTH-1:1]};

    // One restoring divide step; a zero divisor always "fits", giving all-ones / dividend.
    assign div_shift = {rem[WIDTH-1:0], quot[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_r};
    assign div_fits  = ~div_diff[WIDTH];
    assign rem_next  = div_fits ? div_diff : div_shift;
    assign quot_next = {quot[WIDTH-2:0], div_fits};

    // Select the final result from the values produced by the last iteration.
    always_comb begin
        result_next = prod_next[WIDTH-1:0];
        case (op_r)
            OP_MUL:   result_next = prod_next[WIDTH-1:0];
            OP_MULHU: result_next = prod_next[2*WIDTH-1:WIDTH];
            OP_DIVU:  result_next = quot_next;
            OP_REMU:  result_next = rem_next[WIDTH-1:0];
            default:  result_next = prod_next[WIDTH-1:0];
        endcase
    end

    // Control FSM, datapath iteration and registered handshake/write-back outputs.
    // NOTE: every register in this block uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            op_r    <= OP_MUL;
            a_r     <= '0;
            b_r     <= '0;
            dest_r  <= '0;
            cnt     <= '0;
            prod    <= '0;
            rem     <= '0;
            quot    <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_en   <= 1'b0;
            wb_reg  <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op_t'(op);
                        a_r    <= src_a;
                        b_r    <= src_b;
                        dest_r <= dest;
                        cnt    <= '0;
                        state  <= CALC;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) begin
                        prod <= {{WIDTH{1'b0}}, b_r};
                        rem  <= '0;
                        quot <= a_r;
                    end else begin
                        prod <= prod_next;
                        rem  <= rem_next;
                        quot <= quot_next;
                    end
                    if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        wb_en   <= 1'b1;
                        wb_reg  <= dest_r;
                        wb_data <= result_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    wb_en <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    wb_en <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit.
// The scoreboard queue is filled at each accepted start.
// A negedge monitor pops an entry and compares on every wb_en pulse.
module tb_mul_div_unit;

    localparam int WIDTH = 16;
    localparam int RAW   = 2;
    localparam int LAT   = 17;

    localparam logic [1:0] MUL   = 2'b00;
    localparam logic [1:0] MULHU = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] REMU  = 2'b11;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = '0;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic [RAW-1:0]   dest = '0;
    logic             ready, busy, done, wb_en;
    logic [RAW-1:0]   wb_reg;
    logic [WIDTH-1:0] wb_data;

    mul_div_unit #(.WIDTH(WIDTH), .REG_ADDR_W(RAW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .dest(dest),
        .ready(ready), .busy(busy), .done(done), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct {
        logic [RAW-1:0]   wreg;
        logic [WIDTH-1:0] data;
        int               accept;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   last_accept = 0;
    int   last_done_cycle = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: compare every write-back against the oldest expected entry.
    logic             prev_wb = 1'b0;
    logic             have_last = 1'b0;
    logic [WIDTH-1:0] last_data = '0;
    logic [RAW-1:0]   last_reg = '0;
    exp_t             e;
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wb_en", 32'd1, 32'd0);
                have_last = 1'b0;
            end else begin
                e = sb.pop_front();
                check({e.name, "_data"}, 32'(wb_data), 32'(e.data));
                check({e.name, "_reg"}, 32'(wb_reg), 32'(e.wreg));
                check({e.name, "_latency"}, 32'(cycle - e.accept), 32'(LAT));
                check({e.name, "_done"}, 32'(done), 32'd1);
                check({e.name, "_busy"}, 32'(busy), 32'd1);
                check({e.name, "_ready"}, 32'(ready), 32'd0);
                last_data = e.data;
                last_reg  = e.wreg;
                have_last = 1'b1;
            end
            last_done_cycle = cycle;
        end else if (prev_wb && have_last) begin
            check("hold_wb_data", 32'(wb_data), 32'(last_data));
            check("hold_wb_reg", 32'(wb_reg), 32'(last_reg));
            check("done_dropped", 32'(done), 32'd0);
            check("ready_back", 32'(ready), 32'd1);
        end
        prev_wb = wb_en;
    end

    // Issue one operation; called at a negedge while the unit is idle.
    task automatic issue(input string name, input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [RAW-1:0] d,
                         input logic [WIDTH-1:0] exp, input bit push);
        check({name, "_ready_at_start"}, 32'(ready), 32'd1);
        start = 1'b1; op = o; src_a = a; src_b = b; dest = d;
        @(posedge clk);
        #1;
        last_accept = cycle;
        if (push) sb.push_back('{d, exp, cycle, name});
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); src_a = 16'($urandom); src_b = 16'($urandom); dest = 2'($urandom);
    endtask

    // Bounded wait for ready, ending on a negedge.
    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [RAW-1:0] d,
                       input logic [WIDTH-1:0] exp);
        issue(name, o, a, b, d, exp, 1'b1);
        wait_ready(name);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_wb_reg", 32'(wb_reg), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run("mul_basic",   MUL,   16'h1234, 16'h0010, 2'd1, 16'h2340);
        run("mulhu_basic", MULHU, 16'h1234, 16'h0010, 2'd1, 16'h0001);
        run("mul_max",     MUL,   16'hFFFF, 16'hFFFF, 2'd2, 16'h0001);
        run("mulhu_max",   MULHU, 16'hFFFF, 16'hFFFF, 2'd3, 16'hFFFE);
        run("mul_zero",    MUL,   16'h0000, 16'hABCD, 2'd0, 16'h0000);
        run("mulhu_zero",  MULHU, 16'h0000, 16'hABCD, 2'd1, 16'h0000);
        run("divu_100_7",  DIVU,  16'd100,  16'd7,    2'd3, 16'h000E);
        run("remu_100_7",  REMU,  16'd100,  16'd7,    2'd2, 16'h0002);
        run("divu_5_9",    DIVU,  16'h0005, 16'h0009, 2'd0, 16'h0000);
        run("remu_5_9",    REMU,  16'h0005, 16'h0009, 2'd1, 16'h0005);
        run("divu_by0",    DIVU,  16'h1234, 16'h0000, 2'd2, 16'hFFFF);
        run("remu_by0",    REMU,  16'h1234, 16'h0000, 2'd3, 16'h1234);

        // Starts while busy are ignored; operand changes after accept have no effect.
        issue("divu_ignore", DIVU, 16'd100, 16'd7, 2'd3, 16'h000E, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 3) src_a = 16'hFFFF;
            if (k == 4 || k == 15 || k == 17) begin
                start = 1'b1; op = MUL; src_a = 16'h0003; src_b = 16'h0007; dest = 2'd0;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("ready_after_ignore", 32'(ready), 32'd1);
        wait_ready("divu_ignore");

        // Start issued in the very first ready cycle is accepted.
        issue("remu_b2b", REMU, 16'd100, 16'd7, 2'd0, 16'h0002, 1'b1);
        check("b2b_accept_gap", 32'(last_accept - last_done_cycle), 32'd2);
        wait_ready("remu_b2b");

        // Reset in mid-operation aborts without a write-back.
        issue("mul_abort", MUL, 16'h1234, 16'h5678, 2'd1, 16'h0000, 1'b0);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wb_en", 32'(wb_en), 32'd0);
        check("abort_wb_data", 32'(wb_data), 32'd0);
        check("abort_wb_reg", 32'(wb_reg), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        run("mul_after_rst", MUL, 16'd3, 16'd5, 2'd2, 16'h000F);

        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
